watch_set_ctrl: RTL and testbench
=================================

WATCH_SET_CTRL -- requirements
Module: watch_set_ctrl

Interface
REQ-001 SHALL have parameter TICK_HZ, default 100, rate of i_tick pulses in Hz.
REQ-002 SHALL have parameter TIMEOUT_S, default 10, idle seconds before automatic exit from set mode.
REQ-003 SHALL have parameter BLINK_TICKS, default 50, i_tick pulses per o_blink half-period.
REQ-004 SHALL have parameters REPEAT_DELAY, default 50, and REPEAT_RATE, default 10: auto-repeat hold delay and repeat period, both in i_tick pulses.
REQ-005 SHALL have port clk, input, 1, the single clock.
REQ-006 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 SHALL have port i_tick, input, 1, one-cycle pulse at TICK_HZ.
REQ-008 SHALL have ports btn_mode, btn_next, btn_clear, btn_up, btn_down, each input, 1, a debounced active-high level.
REQ-009 SHALL have port o_set_mode, output, 1, high while in any SET state.
REQ-010 SHALL have port o_digit_en, output, 3, one-hot {hour, min, sec} counter enable; all zero in RUN.
REQ-011 SHALL have ports o_inc, o_dec, o_clear, each output, 1, a one-cycle command pulse to the enabled counter.
REQ-012 SHALL have port o_run, output, 1, which gates i_tick into the time counters.
REQ-013 SHALL have port o_blink, output, 1, display blink phase for the selected digit.

Function
REQ-014 SHALL detect a rising edge as the current level high and the previous registered level low; the resulting output pulse SHALL be high for exactly the one cycle after the sampling edge.
REQ-015 SHALL implement an FSM with states RUN, SET_HOUR, SET_MIN, SET_SEC.
REQ-016 In RUN, SHALL drive o_run=1 and o_digit_en=000, hold o_inc/o_dec/o_clear at 0, and move to SET_HOUR on a btn_mode edge.
REQ-017 In SET states, SHALL drive o_run=0, hold o_digit_en one-hot (HOUR=100, MIN=010, SEC=001), and advance SET_HOUR->SET_MIN->SET_SEC->SET_HOUR on each btn_next edge.
REQ-018 In SET states, SHALL move to RUN on a btn_mode edge or on timeout.
REQ-019 Event priority in one cycle SHALL be: mode, then next, then clear, then up/down; a lower-priority event that coincides with a higher one SHALL be dropped.
REQ-020 SHALL drop simultaneous up and down edges, emitting neither o_inc nor o_dec.
REQ-021 SHALL assert o_clear only when o_digit_en has been unchanged for at least 2 prior cycles, which satisfies the counter's 2-stage enable delay; otherwise the clear SHALL be dropped.
REQ-022 Timeout counter SHALL count i_tick pulses in SET states and zero on any button edge or repeat pulse; on reaching TIMEOUT_S*TICK_HZ it SHALL force RUN; width SHALL be $clog2(TIMEOUT_S*TICK_HZ+1).
REQ-023 o_blink SHALL be 1 on SET entry, toggle every BLINK_TICKS i_tick pulses, restart at 1 on each digit change, and be 0 in RUN.
REQ-024 Command pulses SHALL never be emitted in RUN, including when a button level is held across SET->RUN.

Reset
REQ-025 On rst sampled high, SHALL set state RUN, o_run=1, and o_set_mode, o_digit_en, o_inc, o_dec, o_clear, o_blink, timeout and blink counters all to 0.
REQ-026 SHALL reset previous-level registers to 1, so a button held through reset produces no pulse until released and pressed again.
REQ-027 rst asserted mid-SET or mid-repeat SHALL abort to RUN in the next cycle with no pending pulse.

Configuration
REQ-028 With macro WATCH_SET_AUTOREPEAT_EN defined, a btn_up/btn_down level held for REPEAT_DELAY i_tick pulses after its edge SHALL emit an extra o_inc/o_dec every REPEAT_RATE pulses while held; release SHALL stop repeats immediately.
REQ-029 Without WATCH_SET_AUTOREPEAT_EN, SHALL emit only one pulse per edge, and the repeat counters SHALL not be synthesized.

Structure
REQ-030 Package watch_pkg SHALL hold the state enum, the digit one-hot constants and the default parameter values.
REQ-031 Sub-module btn_edge_repeat (edge detect plus optional auto-repeat) SHALL be instantiated for btn_up and btn_down; the other buttons SHALL use plain edge logic.

Verification
REQ-032 Reset, then btn_mode pulse -> o_set_mode=1, o_digit_en=100, o_run=0, o_blink=1.
REQ-033 In SET_HOUR, 3 btn_next edges -> o_digit_en sequence 010, 001, 100.
REQ-034 In SET_MIN, btn_up and btn_down rising in the same cycle -> no o_inc/o_dec; then btn_up alone -> one o_inc, one cycle wide.
REQ-035 In SET, no button for 1000 i_tick pulses (defaults) -> RUN, o_run=1, o_digit_en=000; at 999 pulses still SET.
REQ-036 btn_next and btn_clear edges in the same cycle -> digit advances, no o_clear; btn_clear 2 cycles later -> o_clear=1 for 1 cycle.
REQ-037 With WATCH_SET_AUTOREPEAT_EN, btn_up held for 80 ticks -> o_inc at edge, then at ticks 50, 60, 70, 80 (5 total).

Source files
------------

// File: rtl/watch_pkg.sv
// Shared types and defaults for the watch set-mode controller.
package watch_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_SET_HOUR = 2'd1,
    ST_SET_MIN  = 2'd2,
    ST_SET_SEC  = 2'd3
  } state_e;

  localparam int unsigned DIGIT_W = 3;

  localparam logic [DIGIT_W-1:0] DIGIT_NONE = 3'b000;
  localparam logic [DIGIT_W-1:0] DIGIT_HOUR = 3'b100;
  localparam logic [DIGIT_W-1:0] DIGIT_MIN  = 3'b010;
  localparam logic [DIGIT_W-1:0] DIGIT_SEC  = 3'b001;

  localparam int unsigned DEF_TICK_HZ      = 100;
  localparam int unsigned DEF_TIMEOUT_S    = 10;
  localparam int unsigned DEF_BLINK_TICKS  = 50;
  localparam int unsigned DEF_REPEAT_DELAY = 50;
  localparam int unsigned DEF_REPEAT_RATE  = 10;

  // One-hot counter enable for a state; RUN enables nothing.
  function automatic logic [DIGIT_W-1:0] digit_of(input state_e s);
    logic [DIGIT_W-1:0] r;
    case (s)
      ST_SET_HOUR: r = DIGIT_HOUR;
      ST_SET_MIN:  r = DIGIT_MIN;
      ST_SET_SEC:  r = DIGIT_SEC;
      default:     r = DIGIT_NONE;
    endcase
    return r;
  endfunction

  // Digit rotation HOUR -> MIN -> SEC -> HOUR.
  function automatic state_e next_digit(input state_e s);
    state_e r;
    case (s)
      ST_SET_HOUR: r = ST_SET_MIN;
      ST_SET_MIN:  r = ST_SET_SEC;
      ST_SET_SEC:  r = ST_SET_HOUR;
      default:     r = s;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/btn_edge_repeat.sv
// Rising-edge detector with optional hold-to-repeat pulse generator.
// Repeat logic exists only when WATCH_SET_AUTOREPEAT_EN is defined.
module btn_edge_repeat
  import watch_pkg::*;
#(
  parameter int unsigned REPEAT_DELAY = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_RATE  = DEF_REPEAT_RATE
) (
  input  logic clk,
  input  logic rst,
  input  logic i_tick,
  input  logic i_level,
  output logic o_edge,
  output logic o_repeat
);

  logic prev_q, prev_d;
  logic edge_q, edge_d;

  // Edge detect against the previous registered level.
  always_comb begin
    prev_d = i_level;
    edge_d = i_level & ~prev_q;
  end

  // Previous level resets high so a held button gives no edge after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= 1'b1;
      edge_q <= 1'b0;
    end else begin
      prev_q <= prev_d;
      edge_q <= edge_d;
    end
  end

  assign o_edge = edge_q;

`ifdef WATCH_SET_AUTOREPEAT_EN
  localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned RPT_W   = $clog2(RPT_MAX + 1);

  logic             armed_q, armed_d;
  logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
  logic             rpt_q, rpt_d;

  // Count ticks down from the edge: first DELAY, then every RATE while held.
  always_comb begin
    armed_d   = armed_q;
    rpt_cnt_d = rpt_cnt_q;
    rpt_d     = 1'b0;
    if (!i_level) begin
      armed_d   = 1'b0;
      rpt_cnt_d = '0;
    end else if (edge_d) begin
      armed_d   = 1'b1;
      rpt_cnt_d = RPT_W'(REPEAT_DELAY);
    end else if (armed_q && i_tick) begin
      if (rpt_cnt_q <= RPT_W'(1)) begin
        rpt_d     = 1'b1;
        rpt_cnt_d = RPT_W'(REPEAT_RATE);
      end else begin
        rpt_cnt_d = rpt_cnt_q - RPT_W'(1);
      end
    end
  end

  // Repeat state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      armed_q   <= 1'b0;
      rpt_cnt_q <= '0;
      rpt_q     <= 1'b0;
    end else begin
      armed_q   <= armed_d;
      rpt_cnt_q <= rpt_cnt_d;
      rpt_q     <= rpt_d;
    end
  end

  assign o_repeat = rpt_q;
`else
  logic unused_ok;
  assign unused_ok = ^{i_tick, REPEAT_DELAY[0], REPEAT_RATE[0]};
  assign o_repeat  = 1'b0;
`endif

endmodule

// File: rtl/watch_set_ctrl.sv
// Watch set-mode controller: selects the digit being edited, issues
// inc/dec/clear pulses, blinks the selected digit and times out to RUN.
// Optional hold-to-repeat on up/down: define WATCH_SET_AUTOREPEAT_EN.
module watch_set_ctrl
  import watch_pkg::*;
#(
  parameter int unsigned TICK_HZ      = DEF_TICK_HZ,
  parameter int unsigned TIMEOUT_S    = DEF_TIMEOUT_S,
  parameter int unsigned BLINK_TICKS  = DEF_BLINK_TICKS,
  parameter int unsigned REPEAT_DELAY = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_RATE  = DEF_REPEAT_RATE
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_tick,
  input  logic               btn_mode,
  input  logic               btn_next,
  input  logic               btn_clear,
  input  logic               btn_up,
  input  logic               btn_down,
  output logic               o_set_mode,
  output logic [DIGIT_W-1:0] o_digit_en,
  output logic               o_inc,
  output logic               o_dec,
  output logic               o_clear,
  output logic               o_run,
  output logic               o_blink
);

  localparam int unsigned TO_LIMIT = TIMEOUT_S * TICK_HZ;
  localparam int unsigned TO_W     = $clog2(TO_LIMIT + 1);
  localparam int unsigned BL_W     = $clog2(BLINK_TICKS + 1);
  localparam int unsigned HOLD_W   = 2;

  logic [2:0]         lvl;
  logic [2:0]         prev_q, prev_d;
  logic [2:0]         edge_q, edge_d;
  logic               up_edge, up_rep, dn_edge, dn_rep;
  logic               mode_ev, next_ev, clr_ev, up_ev, dn_ev, any_ev;
  state_e             state_q, state_d;
  logic [DIGIT_W-1:0] digit_q, digit_d;
  logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
  logic [BL_W-1:0]    bl_cnt_q, bl_cnt_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic               blink_q, blink_d;
  logic               run_q, run_d;
  logic               set_mode_q, set_mode_d;
  logic               inc_q, inc_d;
  logic               dec_q, dec_d;
  logic               clear_q, clear_d;

  btn_edge_repeat #(
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_RATE  (REPEAT_RATE)
  ) u_up (
    .clk      (clk),
    .rst      (rst),
    .i_tick   (i_tick),
    .i_level  (btn_up),
    .o_edge   (up_edge),
    .o_repeat (up_rep)
  );

  btn_edge_repeat #(
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_RATE  (REPEAT_RATE)
  ) u_dn (
    .clk      (clk),
    .rst      (rst),
    .i_tick   (i_tick),
    .i_level  (btn_down),
    .o_edge   (dn_edge),
    .o_repeat (dn_rep)
  );

  assign lvl     = {btn_mode, btn_next, btn_clear};
  assign mode_ev = edge_q[2];
  assign next_ev = edge_q[1];
  assign clr_ev  = edge_q[0];
  assign up_ev   = up_edge | up_rep;
  assign dn_ev   = dn_edge | dn_rep;
  assign any_ev  = mode_ev | next_ev | clr_ev | up_ev | dn_ev;

  // Plain edge detect for mode/next/clear.
  always_comb begin
    prev_d = lvl;
    edge_d = lvl & ~prev_q;
  end

  // Next state, prioritised commands, timeout, blink and enable-stability tracking.
  always_comb begin
    state_d  = state_q;
    to_cnt_d = to_cnt_q;
    bl_cnt_d = bl_cnt_q;
    blink_d  = blink_q;
    hold_d   = hold_q;
    inc_d    = 1'b0;
    dec_d    = 1'b0;
    clear_d  = 1'b0;

    if (state_q == ST_RUN) begin
      if (mode_ev) state_d = ST_SET_HOUR;
    end else begin
      if (mode_ev) begin
        state_d = ST_RUN;
      end else if (next_ev) begin
        state_d = next_digit(state_q);
      end else if (clr_ev) begin
        clear_d = (hold_q >= HOLD_W'(2));
      end else if (up_ev && !dn_ev) begin
        inc_d = 1'b1;
      end else if (dn_ev && !up_ev) begin
        dec_d = 1'b1;
      end
      if (!any_ev && i_tick && (to_cnt_q == TO_W'(TO_LIMIT - 1))) state_d = ST_RUN;
    end

    if ((state_d == ST_RUN) || any_ev) begin
      to_cnt_d = '0;
    end else if (i_tick) begin
      to_cnt_d = to_cnt_q + TO_W'(1);
    end

    digit_d = digit_of(state_d);

    // Cycles the current enable value has been on the output, saturating.
    if (digit_d != digit_q) begin
      hold_d = HOLD_W'(1);
    end else if (hold_q != '1) begin
      hold_d = hold_q + HOLD_W'(1);
    end

    if (state_d == ST_RUN) begin
      blink_d  = 1'b0;
      bl_cnt_d = '0;
    end else if (digit_d != digit_q) begin
      blink_d  = 1'b1;
      bl_cnt_d = '0;
    end else if (i_tick) begin
      if (bl_cnt_q == BL_W'(BLINK_TICKS - 1)) begin
        blink_d  = ~blink_q;
        bl_cnt_d = '0;
      end else begin
        bl_cnt_d = bl_cnt_q + BL_W'(1);
      end
    end

    run_d      = (state_d == ST_RUN);
    set_mode_d = (state_d != ST_RUN);
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RUN;
      prev_q     <= '1;
      edge_q     <= '0;
      digit_q    <= DIGIT_NONE;
      to_cnt_q   <= '0;
      bl_cnt_q   <= '0;
      hold_q     <= '0;
      blink_q    <= 1'b0;
      run_q      <= 1'b1;
      set_mode_q <= 1'b0;
      inc_q      <= 1'b0;
      dec_q      <= 1'b0;
      clear_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      edge_q     <= edge_d;
      digit_q    <= digit_d;
      to_cnt_q   <= to_cnt_d;
      bl_cnt_q   <= bl_cnt_d;
      hold_q     <= hold_d;
      blink_q    <= blink_d;
      run_q      <= run_d;
      set_mode_q <= set_mode_d;
      inc_q      <= inc_d;
      dec_q      <= dec_d;
      clear_q    <= clear_d;
    end
  end

  assign o_set_mode = set_mode_q;
  assign o_digit_en = digit_q;
  assign o_inc      = inc_q;
  assign o_dec      = dec_q;
  assign o_clear    = clear_q;
  assign o_run      = run_q;
  assign o_blink    = blink_q;

endmodule

// File: tb/tb_watch_set_ctrl.sv
// Self-checking bench for watch_set_ctrl with default parameters.
module tb_watch_set_ctrl;

  localparam int TO_TICKS  = 1000;
  localparam int BLINK_T   = 50;
  localparam int RPT_DELAY = 50;
  localparam int RPT_RATE  = 10;

  localparam logic [4:0] B_MODE = 5'b10000;
  localparam logic [4:0] B_NEXT = 5'b01000;
  localparam logic [4:0] B_CLR  = 5'b00100;
  localparam logic [4:0] B_UP   = 5'b00010;
  localparam logic [4:0] B_DN   = 5'b00001;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i_tick = 1'b0;
  logic       btn_mode = 1'b0, btn_next = 1'b0, btn_clear = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
  logic       o_set_mode, o_inc, o_dec, o_clear, o_run, o_blink;
  logic [2:0] o_digit_en;

  int n_checks = 0;
  int n_fail   = 0;
  int m_digit  = 0;
  int ticks_sent = 0;
  int inc_cnt = 0, dec_cnt = 0, clr_cnt = 0, wide_cnt = 0;
  logic inc_p = 1'b0, dec_p = 1'b0, clr_p = 1'b0;
  int inc_ticks[$];

  watch_set_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .i_tick     (i_tick),
    .btn_mode   (btn_mode),
    .btn_next   (btn_next),
    .btn_clear  (btn_clear),
    .btn_up     (btn_up),
    .btn_down   (btn_down),
    .o_set_mode (o_set_mode),
    .o_digit_en (o_digit_en),
    .o_inc      (o_inc),
    .o_dec      (o_dec),
    .o_clear    (o_clear),
    .o_run      (o_run),
    .o_blink    (o_blink)
  );

  always #5 clk = ~clk;

  // Pulse monitor on the falling edge.
  always @(negedge clk) begin
    if (o_inc === 1'b1) begin
      inc_cnt++;
      inc_ticks.push_back(ticks_sent);
    end
    if (o_dec === 1'b1) dec_cnt++;
    if (o_clear === 1'b1) clr_cnt++;
    if ((o_inc === 1'b1 && inc_p) || (o_dec === 1'b1 && dec_p) || (o_clear === 1'b1 && clr_p))
      wide_cnt++;
    inc_p = (o_inc === 1'b1);
    dec_p = (o_dec === 1'b1);
    clr_p = (o_clear === 1'b1);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [2:0] exp_en(input int d);
    if (d == 0) return 3'b000;
    return 3'(4 >> (d - 1));
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_btns(input logic [4:0] b);
    {btn_mode, btn_next, btn_clear, btn_up, btn_down} = b;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      i_tick = 1'b1;
      ticks_sent++;
      step(1);
      i_tick = 1'b0;
      step(3);
    end
  endtask

  task automatic press(input logic [4:0] b);
    set_btns(b);
    step(1);
    set_btns(5'b0);
    step(4);
  endtask

  task automatic clear_mon();
    inc_cnt = 0; dec_cnt = 0; clr_cnt = 0; wide_cnt = 0;
    inc_ticks.delete();
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    set_btns(5'b0);
    i_tick = 1'b0;
    step(2);
    rst = 1'b0;
    step(1);
    m_digit = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(3);
    n_checks++;
    if ({o_run, o_set_mode, o_digit_en, o_inc, o_dec, o_clear, o_blink} !== 9'b1_0_000_0000) begin
      n_fail++;
      $display("FAIL reset_in: got %b expected 100000000",
               {o_run, o_set_mode, o_digit_en, o_inc, o_dec, o_clear, o_blink});
    end
    rst = 1'b0;
    step(3);
    n_checks++;
    if ({o_run, o_set_mode, o_digit_en, o_blink} !== 6'b1_0_000_0) begin
      n_fail++;
      $display("FAIL reset_out: got %b expected 100000", {o_run, o_set_mode, o_digit_en, o_blink});
    end
    m_digit = 0;
  endtask

  task automatic test_held_reset();
    set_btns(B_MODE);
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    step(4);
    n_checks++;
    if (o_set_mode !== 1'b0) begin
      n_fail++;
      $display("FAIL held_through_reset: set_mode=%b expected 0", o_set_mode);
    end
    set_btns(5'b0);
    step(2);
    press(B_MODE);
    m_digit = 1;
    n_checks++;
    if (o_set_mode !== 1'b1 || o_digit_en !== exp_en(m_digit)) begin
      n_fail++;
      $display("FAIL held_repress: set_mode=%b en=%b expected 1 %b", o_set_mode, o_digit_en, exp_en(m_digit));
    end
    press(B_MODE);
    m_digit = 0;
  endtask

  task automatic test_mode_entry();
    reset_dut();
    press(B_MODE);
    m_digit = 1;
    n_checks++;
    if ({o_set_mode, o_digit_en, o_run, o_blink} !== 6'b1_100_0_1) begin
      n_fail++;
      $display("FAIL mode_entry: got %b expected 110001", {o_set_mode, o_digit_en, o_run, o_blink});
    end
  endtask

  task automatic test_next_seq();
    for (int i = 0; i < 3; i++) begin
      press(B_NEXT);
      m_digit = m_digit % 3 + 1;
      n_checks++;
      if (o_digit_en !== exp_en(m_digit)) begin
        n_fail++;
        $display("FAIL next_seq[%0d]: en=%b expected %b", i, o_digit_en, exp_en(m_digit));
      end
    end
  endtask

  task automatic test_up_down();
    press(B_NEXT);
    m_digit = m_digit % 3 + 1;
    clear_mon();
    set_btns(B_UP | B_DN);
    step(2);
    set_btns(5'b0);
    step(4);
    n_checks++;
    if (inc_cnt != 0 || dec_cnt != 0) begin
      n_fail++;
      $display("FAIL up_down_same: inc=%0d dec=%0d expected 0 0", inc_cnt, dec_cnt);
    end
    press(B_UP);
    n_checks++;
    if (inc_cnt != 1 || dec_cnt != 0 || wide_cnt != 0 || o_digit_en !== 3'b010) begin
      n_fail++;
      $display("FAIL up_alone: inc=%0d dec=%0d wide=%0d en=%b expected 1 0 0 010",
               inc_cnt, dec_cnt, wide_cnt, o_digit_en);
    end
  endtask

  task automatic test_next_clear();
    clear_mon();
    set_btns(B_NEXT | B_CLR);
    step(1);
    set_btns(5'b0);
    step(1);
    set_btns(B_CLR);
    step(1);
    set_btns(5'b0);
    step(4);
    m_digit = m_digit % 3 + 1;
    n_checks++;
    if (o_digit_en !== exp_en(m_digit) || clr_cnt != 1 || wide_cnt != 0) begin
      n_fail++;
      $display("FAIL next_then_clear: en=%b clr=%0d wide=%0d expected %b 1 0",
               o_digit_en, clr_cnt, wide_cnt, exp_en(m_digit));
    end
    clear_mon();
    set_btns(B_NEXT);
    step(1);
    set_btns(B_CLR);
    step(1);
    set_btns(5'b0);
    step(4);
    m_digit = m_digit % 3 + 1;
    n_checks++;
    if (o_digit_en !== exp_en(m_digit) || clr_cnt != 0) begin
      n_fail++;
      $display("FAIL clear_too_soon: en=%b clr=%0d expected %b 0", o_digit_en, clr_cnt, exp_en(m_digit));
    end
  endtask

  task automatic test_timeout();
    tick(TO_TICKS - 1);
    n_checks++;
    if (o_set_mode !== 1'b1 || o_run !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_early: set_mode=%b run=%b expected 1 0", o_set_mode, o_run);
    end
    tick(1);
    m_digit = 0;
    n_checks++;
    if (o_run !== 1'b1 || o_digit_en !== 3'b000 || o_set_mode !== 1'b0 || o_blink !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_exit: run=%b en=%b set=%b blink=%b expected 1 000 0 0",
               o_run, o_digit_en, o_set_mode, o_blink);
    end
  endtask

  task automatic test_blink();
    logic exp_b;
    press(B_MODE);
    m_digit = 1;
    exp_b = 1'b1;
    tick(BLINK_T - 1);
    n_checks++;
    if (o_blink !== exp_b) begin
      n_fail++;
      $display("FAIL blink_hold: blink=%b expected %b", o_blink, exp_b);
    end
    tick(1);
    exp_b = ~exp_b;
    n_checks++;
    if (o_blink !== exp_b) begin
      n_fail++;
      $display("FAIL blink_toggle: blink=%b expected %b", o_blink, exp_b);
    end
    press(B_NEXT);
    m_digit = 2;
    exp_b = 1'b1;
    n_checks++;
    if (o_blink !== exp_b) begin
      n_fail++;
      $display("FAIL blink_restart: blink=%b expected %b", o_blink, exp_b);
    end
    tick(2 * BLINK_T);
    n_checks++;
    if (o_blink !== exp_b) begin
      n_fail++;
      $display("FAIL blink_period: blink=%b expected %b", o_blink, exp_b);
    end
    press(B_MODE);
    m_digit = 0;
    n_checks++;
    if (o_blink !== 1'b0 || o_run !== 1'b1) begin
      n_fail++;
      $display("FAIL blink_run: blink=%b run=%b expected 0 1", o_blink, o_run);
    end
  endtask

  task automatic test_run_no_cmd();
    clear_mon();
    press(B_UP);
    press(B_DN);
    press(B_CLR);
    press(B_MODE);
    set_btns(B_UP);
    step(3);
    set_btns(B_UP | B_MODE);
    step(1);
    set_btns(B_UP);
    step(3);
    tick(RPT_DELAY + 3 * RPT_RATE);
    set_btns(5'b0);
    step(3);
    n_checks++;
    if (inc_cnt != 1 || dec_cnt != 0 || clr_cnt != 0 || o_run !== 1'b1) begin
      n_fail++;
      $display("FAIL run_no_cmd: inc=%0d dec=%0d clr=%0d run=%b expected 1 0 0 1",
               inc_cnt, dec_cnt, clr_cnt, o_run);
    end
    m_digit = 0;
  endtask

  task automatic test_autorepeat();
    int exp_q[$];
    int held = 80;
    press(B_MODE);
    m_digit = 1;
    clear_mon();
    ticks_sent = 0;
    exp_q.push_back(0);
`ifdef WATCH_SET_AUTOREPEAT_EN
    for (int t = RPT_DELAY; t <= held; t += RPT_RATE) exp_q.push_back(t);
`endif
    set_btns(B_UP);
    step(3);
    tick(held);
    set_btns(5'b0);
    step(2);
    tick(20);
    n_checks++;
    if (inc_ticks.size() != exp_q.size() || wide_cnt != 0) begin
      n_fail++;
      $display("FAIL repeat_count: inc=%0d wide=%0d expected %0d 0", inc_ticks.size(), wide_cnt, exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_checks++;
        if (inc_ticks[i] != exp_q[i]) begin
          n_fail++;
          $display("FAIL repeat_tick[%0d]: at tick %0d expected %0d", i, inc_ticks[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_set();
    set_btns(B_UP);
    step(2);
    tick(RPT_DELAY + 5);
    rst = 1'b1;
    step(1);
    n_checks++;
    if (o_run !== 1'b1 || o_set_mode !== 1'b0 || o_digit_en !== 3'b000 || o_inc !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_set: run=%b set=%b en=%b inc=%b expected 1 0 000 0",
               o_run, o_set_mode, o_digit_en, o_inc);
    end
    rst = 1'b0;
    clear_mon();
    tick(2 * RPT_RATE);
    set_btns(5'b0);
    step(3);
    m_digit = 0;
    n_checks++;
    if (inc_cnt != 0 || o_run !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_no_pending: inc=%0d run=%b expected 0 1", inc_cnt, o_run);
    end
  endtask

  task automatic test_random();
    logic [4:0] b;
    int exp_inc, exp_dec, exp_clr;
    reset_dut();
    for (int s = 0; s < 40; s++) begin
      b = 5'($urandom_range(1, 31));
      exp_inc = 0; exp_dec = 0; exp_clr = 0;
      if (b[4]) begin
        m_digit = (m_digit == 0) ? 1 : 0;
      end else if (m_digit != 0) begin
        if (b[3]) m_digit = m_digit % 3 + 1;
        else if (b[2]) exp_clr = 1;
        else if (b[1] != b[0]) begin
          exp_inc = int'(b[1]);
          exp_dec = int'(b[0]);
        end
      end
      clear_mon();
      set_btns(b);
      step(1 + $urandom_range(0, 2));
      set_btns(5'b0);
      step(5);
      n_checks++;
      if (o_digit_en !== exp_en(m_digit) || o_run !== (m_digit == 0) || inc_cnt != exp_inc ||
          dec_cnt != exp_dec || clr_cnt != exp_clr || wide_cnt != 0) begin
        n_fail++;
        $display("FAIL random[%0d] btn=%b: en=%b run=%b inc=%0d dec=%0d clr=%0d wide=%0d expected %b %0d %0d %0d %0d 0",
                 s, b, o_digit_en, o_run, inc_cnt, dec_cnt, clr_cnt, wide_cnt,
                 exp_en(m_digit), (m_digit == 0), exp_inc, exp_dec, exp_clr);
      end
    end
  endtask

  initial begin
    test_reset();
    test_held_reset();
    test_mode_entry();
    test_next_seq();
    test_up_down();
    test_next_clear();
    test_timeout();
    test_blink();
    test_run_no_cmd();
    test_autorepeat();
    test_reset_mid_set();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
